// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared widths and round-robin helpers for the memory arbiter.
package memory_arbiter_pkg;

    localparam int MAXN = 32;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_N = 2;
    localparam int AW = $clog2(DEF_DEPTH);
    localparam int IW = $clog2(DEF_N);

    // Walks from the farthest slot back to ptr so the nearest requester wins.
    function automatic int rr_next(input logic [MAXN-1:0] req, input int ptr, input int n);
        int idx;
        rr_next = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (req[idx]) rr_next = idx;
        end
    endfunction

    function automatic int rr_inc(input int i, input int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick with an optional held grant.
module rr_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             hold,
    input  logic [IDX_W-1:0] hold_idx,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = hold ? hold_idx : IDX_W'(rr_next(MAXN'(req), int'(ptr), N));
        gnt = req & (N'(1) << idx);
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory between N requesters with independent
// round-robin write and read-address channels and owner-routed read responses.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = DEF_DEPTH,
    parameter int N = DEF_N,
    localparam int ADR_W = $clog2(DEPTH),
    localparam int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       s_w_stb,
    input  logic [N*ADR_W-1:0] s_w_adr,
    input  logic [N*WIDTH-1:0] s_w_dat,
    output logic [N-1:0]       s_w_rdy,
    input  logic [N-1:0]       s_ar_stb,
    input  logic [N*ADR_W-1:0] s_ar_dat,
    output logic [N-1:0]       s_ar_rdy,
    output logic [N-1:0]       s_r_stb,
    input  logic [N-1:0]       s_r_rdy,
    output logic [WIDTH-1:0]   s_r_dat,
    output logic               m_aw_stb,
    output logic               m_w_stb,
    output logic [ADR_W-1:0]   m_aw_dat,
    output logic [WIDTH-1:0]   m_w_dat,
    input  logic               m_aw_rdy,
    input  logic               m_w_rdy,
    output logic               m_ar_stb,
    output logic [ADR_W-1:0]   m_ar_dat,
    input  logic               m_ar_rdy,
    input  logic               m_r_stb,
    input  logic [WIDTH-1:0]   m_r_dat,
    output logic               m_r_rdy
);

    logic [IDX_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDX_W-1:0] rgnt_q, rgnt_d, owner_q, owner_d;
    logic             rlock_q, rlock_d;
    logic [IDX_W-1:0] widx, ridx;
    logic [N-1:0]     wgnt, rgnt;
    logic             w_acc, ar_acc;
    logic             unused_w_rdy;

    assign unused_w_rdy = m_w_rdy;

    rr_arbiter #(.N(N)) u_warb (
        .req(s_w_stb), .ptr(wptr_q), .hold(1'b0), .hold_idx('0), .gnt(wgnt), .idx(widx)
    );

    // A stalled read address keeps its grant so the payload cannot change under the memory.
    rr_arbiter #(.N(N)) u_rarb (
        .req(s_ar_stb), .ptr(rptr_q), .hold(rlock_q), .hold_idx(rgnt_q), .gnt(rgnt), .idx(ridx)
    );

    always_comb begin
        m_aw_stb = ~rst & |s_w_stb;
        m_w_stb  = m_aw_stb;
        m_aw_dat = s_w_adr[widx*ADR_W +: ADR_W];
        m_w_dat  = s_w_dat[widx*WIDTH +: WIDTH];
        s_w_rdy  = rst ? '0 : wgnt & {N{m_aw_rdy}};
        w_acc    = m_aw_stb & m_aw_rdy;
        m_ar_stb = ~rst & |s_ar_stb;
        m_ar_dat = s_ar_dat[ridx*ADR_W +: ADR_W];
        s_ar_rdy = rst ? '0 : rgnt & {N{m_ar_rdy}};
        ar_acc   = m_ar_stb & m_ar_rdy;
        s_r_stb  = (m_r_stb & ~rst) ? N'(1) << owner_q : '0;
        m_r_rdy  = s_r_rdy[owner_q];
        s_r_dat  = m_r_dat;
        wptr_d   = w_acc ? IDX_W'(rr_inc(int'(widx), N)) : wptr_q;
        rptr_d   = ar_acc ? IDX_W'(rr_inc(int'(ridx), N)) : rptr_q;
        owner_d  = ar_acc ? ridx : owner_q;
        rgnt_d   = m_ar_stb ? ridx : rgnt_q;
        rlock_d  = (m_ar_stb & ~m_ar_rdy) | (rlock_q & ~ar_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rgnt_q  <= '0;
            owner_q <= '0;
            rlock_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rgnt_q  <= rgnt_d;
            owner_q <= owner_d;
            rlock_q <= rlock_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of write/read arbitration, locking,
// response routing and reset against a one-response memory model.
module tb_memory_arbiter;

    localparam int W = 16;
    localparam int D = 256;
    localparam int N = 2;
    localparam int A = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   s_w_stb, s_w_rdy, s_ar_stb, s_ar_rdy, s_r_stb, s_r_rdy;
    logic [N*A-1:0] s_w_adr, s_ar_dat;
    logic [N*W-1:0] s_w_dat;
    logic [W-1:0]   s_r_dat, m_w_dat, m_r_dat;
    logic [A-1:0]   m_aw_dat, m_ar_dat;
    logic           m_aw_stb, m_w_stb, m_aw_rdy, m_w_rdy;
    logic           m_ar_stb, m_ar_rdy, m_r_stb, m_r_rdy;

    logic [W-1:0]   mem [D];
    logic           rvalid;
    logic [W-1:0]   rdata;
    int             n_chk = 0;
    int             n_fail = 0;

    memory_arbiter #(.WIDTH(W), .DEPTH(D), .N(N)) dut (
        .clk(clk), .rst(rst),
        .s_w_stb(s_w_stb), .s_w_adr(s_w_adr), .s_w_dat(s_w_dat), .s_w_rdy(s_w_rdy),
        .s_ar_stb(s_ar_stb), .s_ar_dat(s_ar_dat), .s_ar_rdy(s_ar_rdy),
        .s_r_stb(s_r_stb), .s_r_rdy(s_r_rdy), .s_r_dat(s_r_dat),
        .m_aw_stb(m_aw_stb), .m_w_stb(m_w_stb), .m_aw_dat(m_aw_dat), .m_w_dat(m_w_dat),
        .m_aw_rdy(m_aw_rdy), .m_w_rdy(m_w_rdy),
        .m_ar_stb(m_ar_stb), .m_ar_dat(m_ar_dat), .m_ar_rdy(m_ar_rdy),
        .m_r_stb(m_r_stb), .m_r_dat(m_r_dat), .m_r_rdy(m_r_rdy)
    );

    always #5 clk = ~clk;

    // Memory holding a single read response; a new address is taken once the old one leaves.
    assign m_ar_rdy = ~rvalid | m_r_rdy;
    assign m_r_stb  = rvalid;
    assign m_r_dat  = rdata;

    always @(posedge clk) begin
        if (m_aw_stb && m_aw_rdy) mem[m_aw_dat] <= m_w_dat;
        if (rst) rvalid <= 1'b0;
        else if (m_ar_stb && m_ar_rdy) begin
            rvalid <= 1'b1;
            rdata  <= mem[m_ar_dat];
        end else if (m_r_rdy) rvalid <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        rdata    = '0;
        rst      = 1'b1;
        m_aw_rdy = 1'b1;
        m_w_rdy  = 1'b1;
        s_w_stb  = 2'b11;
        s_w_adr  = {8'd4, 8'd3};
        s_w_dat  = {16'h2222, 16'h1111};
        s_ar_stb = 2'b11;
        s_ar_dat = {8'd4, 8'd3};
        s_r_rdy  = 2'b00;
        tick();
        tick();
        chk("rst_w_rdy", 32'(s_w_rdy), 0);
        chk("rst_ar_rdy", 32'(s_ar_rdy), 0);
        chk("rst_r_stb", 32'(s_r_stb), 0);
        chk("rst_aw_stb", 32'(m_aw_stb), 0);
        chk("rst_w_stb", 32'(m_w_stb), 0);
        chk("rst_ar_stb", 32'(m_ar_stb), 0);
        // Alternating writes, requester 0 first after reset.
        rst = 1'b0;
        s_ar_stb = 2'b00;
        #1;
        chk("w0_rdy", 32'(s_w_rdy), 2'b01);
        chk("w0_adr", 32'(m_aw_dat), 3);
        chk("w0_dat", 32'(m_w_dat), 16'h1111);
        tick();
        chk("w1_rdy", 32'(s_w_rdy), 2'b10);
        chk("w1_adr", 32'(m_aw_dat), 4);
        chk("w1_dat", 32'(m_w_dat), 16'h2222);
        tick();
        chk("w2_rdy", 32'(s_w_rdy), 2'b01);
        tick();
        chk("w3_rdy", 32'(s_w_rdy), 2'b10);
        tick();
        s_w_stb = 2'b00;
        tick();
        chk("mem3", 32'(mem[3]), 16'h1111);
        chk("mem4", 32'(mem[4]), 16'h2222);
        // Req1 response held while req0 waits for the address channel.
        s_ar_stb = 2'b10;
        #1;
        chk("rd1_ar_rdy", 32'(s_ar_rdy), 2'b10);
        tick();
        s_ar_stb = 2'b01;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_r_stb", 32'(s_r_stb), 2'b10);
            chk("stall_r_dat", 32'(s_r_dat), 16'h2222);
            chk("stall_ar_rdy", 32'(s_ar_rdy), 2'b00);
            tick();
        end
        s_r_rdy = 2'b10;
        #1;
        chk("rel_ar_rdy", 32'(s_ar_rdy), 2'b01);
        tick();
        s_ar_stb = 2'b00;
        s_r_rdy = 2'b00;
        #1;
        chk("rel_r_stb", 32'(s_r_stb), 2'b01);
        chk("rel_r_dat", 32'(s_r_dat), 16'h1111);
        s_r_rdy = 2'b01;
        tick();
        chk("rel_idle", 32'(s_r_stb), 2'b00);
        // Lock: req0 stalls with rptr pointing at req1; grant must stay on req0.
        s_r_rdy = 2'b00;
        s_ar_stb = 2'b01;
        #1;
        chk("lk_first", 32'(s_ar_rdy), 2'b01);
        tick();
        s_ar_dat = {8'd3, 8'd4};
        #1;
        chk("lk_stall", 32'(s_ar_rdy), 2'b00);
        tick();
        s_ar_stb = 2'b11;
        #1;
        chk("lk_hold_rdy", 32'(s_ar_rdy), 2'b00);
        chk("lk_hold_adr", 32'(m_ar_dat), 4);
        tick();
        s_r_rdy = 2'b01;
        #1;
        chk("lk_acc_rdy", 32'(s_ar_rdy), 2'b01);
        chk("lk_acc_adr", 32'(m_ar_dat), 4);
        tick();
        s_ar_stb = 2'b10;
        #1;
        chk("lk_r_stb", 32'(s_r_stb), 2'b01);
        chk("lk_r_dat", 32'(s_r_dat), 16'h2222);
        chk("lk_next_rdy", 32'(s_ar_rdy), 2'b10);
        chk("lk_next_adr", 32'(m_ar_dat), 3);
        tick();
        s_ar_stb = 2'b00;
        s_r_rdy = 2'b10;
        #1;
        chk("lk_r1_stb", 32'(s_r_stb), 2'b10);
        chk("lk_r1_dat", 32'(s_r_dat), 16'h1111);
        tick();
        s_r_rdy = 2'b00;
        #1;
        chk("lk_idle", 32'(s_r_stb), 2'b00);
        // Same-address read and write in one cycle returns the old value.
        s_w_stb = 2'b01;
        s_w_adr = {8'd0, 8'd7};
        s_w_dat = {16'h0000, 16'h0005};
        #1;
        chk("w7_rdy", 32'(s_w_rdy), 2'b01);
        tick();
        s_w_stb = 2'b10;
        s_w_adr = {8'd7, 8'd0};
        s_w_dat = {16'h00AA, 16'h0000};
        s_ar_stb = 2'b01;
        s_ar_dat = {8'd7, 8'd7};
        s_r_rdy = 2'b11;
        #1;
        chk("rw_w_rdy", 32'(s_w_rdy), 2'b10);
        chk("rw_ar_rdy", 32'(s_ar_rdy), 2'b01);
        tick();
        s_w_stb = 2'b00;
        s_ar_stb = 2'b10;
        #1;
        chk("rw_old_stb", 32'(s_r_stb), 2'b01);
        chk("rw_old_dat", 32'(s_r_dat), 16'h0005);
        chk("rw_b2b_rdy", 32'(s_ar_rdy), 2'b10);
        tick();
        s_ar_stb = 2'b00;
        #1;
        chk("rw_new_stb", 32'(s_r_stb), 2'b10);
        chk("rw_new_dat", 32'(s_r_dat), 16'h00AA);
        tick();
        // Reset with a pending req1 response, a locked read and wptr advanced.
        s_ar_stb = 2'b10;
        s_ar_dat = {8'd4, 8'd7};
        s_r_rdy = 2'b00;
        s_w_stb = 2'b01;
        s_w_adr = {8'd0, 8'd9};
        s_w_dat = {16'h0000, 16'h0033};
        #1;
        chk("rs_ar_rdy", 32'(s_ar_rdy), 2'b10);
        chk("rs_w_rdy", 32'(s_w_rdy), 2'b01);
        tick();
        s_w_stb = 2'b00;
        s_ar_dat = {8'd3, 8'd7};
        #1;
        chk("rs_r_stb", 32'(s_r_stb), 2'b10);
        chk("rs_stall", 32'(s_ar_rdy), 2'b00);
        tick();
        rst = 1'b1;
        #1;
        chk("rs_during", 32'(s_r_stb), 2'b00);
        tick();
        rst = 1'b0;
        s_ar_stb = 2'b11;
        s_r_rdy = 2'b11;
        s_w_stb = 2'b11;
        #1;
        chk("rs_post_stb", 32'(s_r_stb), 2'b00);
        chk("rs_ar_gnt", 32'(s_ar_rdy), 2'b01);
        chk("rs_ar_adr", 32'(m_ar_dat), 7);
        chk("rs_w_gnt", 32'(s_w_rdy), 2'b01);
        tick();
        s_w_stb = 2'b00;
        s_ar_stb = 2'b10;
        #1;
        chk("rs_r0_stb", 32'(s_r_stb), 2'b01);
        chk("rs_r0_dat", 32'(s_r_dat), 16'h00AA);
        chk("rs_r1_rdy", 32'(s_ar_rdy), 2'b10);
        tick();
        s_ar_stb = 2'b00;
        #1;
        chk("rs_r1_stb", 32'(s_r_stb), 2'b10);
        chk("rs_r1_dat", 32'(s_r_dat), 16'h1111);
        chk("mem9", 32'(mem[9]), 16'h0033);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
